truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
Synthesizable stimulus-and-check stage wrapped around one combinational lab function (gate-level or operator form, 1-bit output Y).
- Upstream side: steps through all 2^N_IN input combinations in ascending binary order, driving the function's inputs with MSB = A.
- Downstream side: samples Y for every combination, captures the response table and compares it against an expected truth table.
- Lets the lab tables run on a board, not only in simulation.

Parameters:
N_IN, 4, number of function inputs; legal range 1..6.
HOLD_CYCLES, 1, clock cycles each vector is held before Y is sampled; must be >= 1.
EXPECTED, 16'h0000, expected truth table; bit i = expected Y for input vector i; only bits 0..2^N_IN-1 are used.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begins a sweep; sampled only in IDLE or DONE.
vec_out  output  N_IN  input vector driven to the function; MSB = A.
dut_y  input  1  function output Y, combinational from vec_out.
busy  output  1  high while a sweep is in progress.
done  output  1  level; high in DONE until the next start or reset.
pass  output  1  done && (err_count == 0).
err_count  output  N_IN+1  number of mismatching vectors; maximum 2^N_IN.
first_err_valid  output  1  at least one mismatch seen this sweep.
first_err_vec  output  N_IN  index of the lowest mismatching vector.
resp_table  output  2^N_IN  captured Y; bit i = Y sampled for vector i.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset, all registers and outputs go to 0 and the FSM enters IDLE; this applies mid-sweep as well, discarding partial results.
- States: IDLE, RUN, DONE.
- IDLE:
  - vec_out = 0, busy = 0.
  - start = 1 -> RUN. On the same edge: idx = 0, hold_cnt = 0, and err_count, first_err_*, resp_table are cleared.
- RUN:
  - vec_out = idx, busy = 1.
  - Each cycle hold_cnt increments.
  - When hold_cnt == HOLD_CYCLES-1, on that edge:
    - resp_table[idx] <= dut_y;
    - if dut_y != EXPECTED[idx]: err_count += 1; and if !first_err_valid, set first_err_vec = idx and first_err_valid = 1.
    - If idx == 2^N_IN-1 -> DONE. Otherwise idx += 1 and hold_cnt = 0.
  - start is ignored in RUN.
- DONE:
  - busy = 0, done = 1. vec_out holds the last vector, 2^N_IN-1. Results stay stable.
  - start = 1 -> RUN, with the same clears as from IDLE; done drops on that edge.
- Latency: start high at edge 0 -> busy high from edge 1. Vector i is driven during cycles [1 + i*HOLD_CYCLES, (i+1)*HOLD_CYCLES] after edge 0. done is asserted on edge 2^N_IN*HOLD_CYCLES + 1.
- Wrap and width rules:
  - idx is N_IN bits wide and never wraps; the last-vector compare ends the sweep.
  - err_count is N_IN+1 bits so the all-fail count 2^N_IN fits without overflow.
  - hold_cnt is sized to clog2(HOLD_CYCLES) bits, minimum 1.
- Simultaneous events: reset has priority over start. start held continuously is harmless: one sweep runs, then another starts immediately from DONE.
- HOLD_CYCLES = 1: every RUN cycle is a sample cycle.

Decomposition:
- Shared header tt_defs.vh holds:
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - a clog2 constant function.
- One sub-module, tt_hold_timer:
  - parameter HOLD_CYCLES; ports clk, reset, clear, en, last.
  - last = en && (cnt == HOLD_CYCLES-1).
- FSM, index, scoreboard and result capture stay in truth_table_sequencer.

Test Plan:
1. N_IN=3, HOLD=1, EXPECTED=8'hE8, majority function as DUT; start pulse at edge 0 -> vec_out steps 0..7 on edges 1..8; done=1 at edge 9; resp_table=8'hE8; err_count=0; pass=1; first_err_valid=0.
2. Same setup with dut_y tied to 0 -> err_count=4, first_err_vec=3, resp_table=8'h00, pass=0, done=1.
3. N_IN=4, HOLD=3, EXPECTED=16'h8000, 4-input AND DUT -> each vector is held exactly 3 cycles; done at edge 49; resp_table=16'h8000; pass=1.
4. N_IN=3, HOLD=1: pulse start again at edge 4, mid-run -> no restart, sweep ends at edge 9 as normal. Then pulse start in DONE -> done drops, results clear, the new sweep repeats scenario 1.
5. N_IN=3, HOLD=1: assert reset at edge 5, mid-sweep -> next edge all outputs 0, state IDLE; after a later start, a full correct sweep gives pass=1.
6. N_IN=3, HOLD=1, EXPECTED=8'hFF with dut_y=0, all vectors failing -> err_count=8 with no overflow, first_err_vec=0.

Source files
------------

// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding and a
// width helper used to size counters from parameters.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Dwell timer: counts the cycles a vector has been held and flags the sample
// cycle (last) once HOLD_CYCLES cycles have elapsed.
module tt_hold_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int            CW       = clog2_min1(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every register sees
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
    end
  end

  assign last = en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 2^N_IN input vectors into a combinational function, captures Y
// for each one and scores the response against the EXPECTED truth table.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int                    N_IN        = 4,
  parameter int                    HOLD_CYCLES = 1,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   dut_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic                   first_err_valid,
  output logic [N_IN-1:0]        first_err_vec,
  output logic [(1<<N_IN)-1:0]   resp_table
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

  state_e          r_state;
  state_e          w_state_next;
  logic [N_IN-1:0] r_idx;
  logic [N_IN:0]   r_err_count;
  logic            r_first_err_valid;
  logic [N_IN-1:0] r_first_err_vec;
  logic [NV-1:0]   r_resp_table;

  logic w_start_sweep;
  logic w_sample;
  logic w_last_vec;
  logic w_mismatch;

  assign w_start_sweep = start && (r_state != ST_RUN);
  assign w_last_vec    = (r_idx == LAST_IDX);
  assign w_mismatch    = (dut_y != EXPECTED[r_idx]);

  tt_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_start_sweep),
    .en    (r_state == ST_RUN),
    .last  (w_sample)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that left w_state_next unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start)                   w_state_next = ST_RUN;
      ST_RUN:  if (w_sample && w_last_vec)  w_state_next = ST_DONE;
      ST_DONE: if (start)                   w_state_next = ST_RUN;
      default:                              w_state_next = ST_IDLE;
    endcase
  end

  // Index, scoreboard and response capture; a new sweep discards old results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx             <= '0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
      r_resp_table      <= '0;
    end else if (w_start_sweep) begin
      r_idx             <= '0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
      r_resp_table      <= '0;
    end else if (w_sample) begin
      r_resp_table[r_idx] <= dut_y;
      if (w_mismatch) begin
        r_err_count <= r_err_count + (N_IN+1)'(1);
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_vec   <= r_idx;
        end
      end
      if (!w_last_vec) begin
        r_idx <= r_idx + N_IN'(1);
      end
    end
  end

  assign vec_out         = r_idx;
  assign busy            = (r_state == ST_RUN);
  assign done            = (r_state == ST_DONE);
  assign pass            = done && (r_err_count == '0);
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_err_valid;
  assign first_err_vec   = r_first_err_vec;
  assign resp_table      = r_resp_table;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: three sequencer configurations; expected sweep results are
// queued at start and popped by a monitor when done rises.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // u_dut3: N_IN=3 HOLD=1 EXP=E8; u_dut4: N_IN=4 HOLD=3 EXP=8000; u_dut3f: N_IN=3 HOLD=1 EXP=FF
  logic        start3, start4, start3f;
  logic [7:0]  fn3, fn3f;
  logic [15:0] fn4;
  logic        y3, y4, y3f;

  logic [2:0]  v3, fev3, v3f, fev3f;
  logic [3:0]  v4, fev4, err3, err3f;
  logic [4:0]  err4;
  logic [7:0]  resp3, resp3f;
  logic [15:0] resp4;
  logic        busy3, done3, pass3, fevv3;
  logic        busy4, done4, pass4, fevv4;
  logic        busy3f, done3f, pass3f, fevv3f;

  assign y3  = fn3[v3];
  assign y4  = fn4[v4];
  assign y3f = fn3f[v3f];

  truth_table_sequencer #(.N_IN(3), .HOLD_CYCLES(1), .EXPECTED(8'hE8)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .vec_out(v3), .dut_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fevv3), .first_err_vec(fev3), .resp_table(resp3));

  truth_table_sequencer #(.N_IN(4), .HOLD_CYCLES(3), .EXPECTED(16'h8000)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .vec_out(v4), .dut_y(y4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_err_valid(fevv4), .first_err_vec(fev4), .resp_table(resp4));

  truth_table_sequencer #(.N_IN(3), .HOLD_CYCLES(1), .EXPECTED(8'hFF)) u_dut3f (
    .clk(clk), .reset(reset), .start(start3f), .vec_out(v3f), .dut_y(y3f),
    .busy(busy3f), .done(done3f), .pass(pass3f), .err_count(err3f),
    .first_err_valid(fevv3f), .first_err_vec(fev3f), .resp_table(resp3f));

  // Monitor view of whichever instance is currently active.
  int          act = 0;
  logic        m_busy, m_done, m_pass, m_fevv;
  logic [3:0]  m_vec, m_fev;
  logic [4:0]  m_err;
  logic [15:0] m_resp;

  always_comb begin
    m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_fevv = 1'b0;
    m_vec = '0; m_fev = '0; m_err = '0; m_resp = '0;
    case (act)
      0: begin
        m_busy = busy3; m_done = done3; m_pass = pass3; m_fevv = fevv3;
        m_vec = {1'b0, v3}; m_fev = {1'b0, fev3}; m_err = {1'b0, err3}; m_resp = {8'h00, resp3};
      end
      1: begin
        m_busy = busy4; m_done = done4; m_pass = pass4; m_fevv = fevv4;
        m_vec = v4; m_fev = fev4; m_err = err4; m_resp = resp4;
      end
      default: begin
        m_busy = busy3f; m_done = done3f; m_pass = pass3f; m_fevv = fevv3f;
        m_vec = {1'b0, v3f}; m_fev = {1'b0, fev3f}; m_err = {1'b0, err3f}; m_resp = {8'h00, resp3f};
      end
    endcase
  end

  typedef struct {
    logic [15:0] resp;
    logic [4:0]  err;
    logic        fevv;
    logic [3:0]  fev;
    logic        pass;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference: Y is read straight off the function table for every vector.
  function automatic exp_t model(input int sel, input logic [15:0] fn, input int s_cyc);
    exp_t        e;
    int          n;
    int          h;
    logic [15:0] expv;
    n    = (sel == 1) ? 4 : 3;
    h    = (sel == 1) ? 3 : 1;
    expv = (sel == 0) ? 16'h00E8 : (sel == 1) ? 16'h8000 : 16'h00FF;
    e.resp = '0; e.err = '0; e.fevv = 1'b0; e.fev = '0;
    for (int i = 0; i < (1 << n); i++) begin
      e.resp[i] = fn[i];
      if (fn[i] != expv[i]) begin
        e.err = e.err + 5'd1;
        if (!e.fevv) begin
          e.fevv = 1'b1;
          e.fev  = 4'(i);
        end
      end
    end
    e.pass     = (e.err == 0);
    e.done_cyc = s_cyc + 1 + (1 << n) * h;
    return e;
  endfunction

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (m_done && !prev_done && !reset) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_table", m_resp, e.resp);
        check("err_count", m_err, e.err);
        check("first_err_valid", m_fevv, e.fevv);
        if (e.fevv) check("first_err_vec", m_fev, e.fev);
        check("pass", m_pass, e.pass);
        check("done_cycle", cyc, e.done_cyc);
      end
    end
    prev_done <= m_done;
  end

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start3  = v;
      1:       start4  = v;
      default: start3f = v;
    endcase
  endtask

  task automatic issue_start(input int sel, input logic [15:0] fn, input bit push);
    @(negedge clk); #1;
    act = sel;
    case (sel)
      0:       fn3  = fn[7:0];
      1:       fn4  = fn;
      default: fn3f = fn[7:0];
    endcase
    set_start(sel, 1'b1);
    if (push) sb.push_back(model(sel, fn, cyc));
    @(negedge clk); #1;
    set_start(sel, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    check("drain_in_budget", sb.size(), 0);
  endtask

  // Called one cycle after the start-sampling edge; poke < 0 disables the extra pulse.
  task automatic watch_sweep(input int n, input int h, input int poke);
    int bad;
    int nv;
    bad = 0;
    nv  = 1 << n;
    for (int k = 0; k < nv * h; k++) begin
      if (m_vec != 4'(k / h) || !m_busy || m_done) bad++;
      if (k == poke) set_start(act, 1'b1);
      else if (k == poke + 1) set_start(act, 1'b0);
      @(negedge clk); #1;
    end
    set_start(act, 1'b0);
    check("sweep_trace_bad_cycles", bad, 0);
    check("done_state", {m_done, m_busy, m_vec}, {1'b1, 1'b0, 4'(nv - 1)});
  endtask

  localparam logic [15:0] MAJ3 = 16'h00E8;

  initial begin
    reset = 1'b1; start3 = 1'b0; start4 = 1'b0; start3f = 1'b0;
    fn3 = '0; fn4 = '0; fn3f = '0;
    repeat (3) @(negedge clk);
    check("reset_dut3", {v3, busy3, done3, pass3, err3, fevv3, fev3, resp3}, 64'd0);
    check("reset_dut4", {v4, busy4, done4, pass4, err4, fevv4, fev4, resp4}, 64'd0);
    check("reset_dut3f", {v3f, busy3f, done3f, pass3f, err3f, fevv3f, fev3f, resp3f}, 64'd0);
    reset = 1'b0;

    // Majority sweep with a start pulse mid-run that must be ignored.
    issue_start(0, MAJ3, 1'b1);
    watch_sweep(3, 1, 3);
    wait_drain(20);

    // Restart from DONE clears results on the start edge.
    issue_start(0, MAJ3, 1'b1);
    check("restart_clear", {m_done, m_busy, m_err, m_resp}, {1'b0, 1'b1, 5'd0, 16'h0000});
    watch_sweep(3, 1, -1);
    wait_drain(20);

    // Y stuck at 0 against the majority table.
    issue_start(0, 16'h0000, 1'b1);
    wait_drain(20);
    check("stuck0_err", m_err, 5'd4);
    check("stuck0_first", {m_fevv, m_fev}, {1'b1, 4'd3});

    // 4-input AND, each vector held three cycles.
    issue_start(1, 16'h8000, 1'b1);
    watch_sweep(4, 3, -1);
    wait_drain(20);
    check("and4_resp", {m_pass, m_resp}, {1'b1, 16'h8000});

    // Every vector failing: count reaches 2^N_IN without wrapping.
    issue_start(2, 16'h0000, 1'b1);
    wait_drain(20);
    check("allfail_err", m_err, 5'd8);
    check("allfail_first", {m_fevv, m_fev}, {1'b1, 4'd0});

    // Reset mid-sweep discards the partial run.
    issue_start(0, MAJ3, 1'b1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(negedge clk); #1;
    check("midreset_dut3", {v3, busy3, done3, pass3, err3, fevv3, fev3, resp3}, 64'd0);
    reset = 1'b0;
    issue_start(0, MAJ3, 1'b1);
    wait_drain(20);
    check("after_reset_pass", m_pass, 1'b1);

    // Random function tables on random configurations.
    repeat (10) begin
      int sel;
      logic [15:0] fn;
      sel = $urandom_range(0, 2);
      fn  = 16'($urandom);
      issue_start(sel, fn, 1'b1);
      wait_drain(80);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
